// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the EX stage.
// Pipelined multiplier, radix-2^DIV_BITS restoring divider, last-result reuse for DIV/REM pairs.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_BITS   = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OP1,
  input  logic [XLEN-1:0] OP2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [2:0]      DBG_STATE
);

  localparam int W2    = 2 * XLEN;
  localparam int ITERS = XLEN / DIV_BITS;
  localparam int CW    = 7;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV_CHK, S_DIV_ITER, S_DIV_FIX, S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      func_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q, dvs_q;
  logic            reuse_v, reuse_sgn;
  logic [XLEN-1:0] reuse_a, reuse_b, reuse_quo, reuse_rem;
  logic [W2-1:0]   prod_q [MUL_STAGES];

  assign DBG_STATE = state;

  // Handshake: START is taken only in IDLE (BUSY=0); BUSY then stays high through
  // the single DONE cycle, and RESULT is meaningful only while DONE is high.

  // Multiplier operands extended to 2*XLEN; only FUNC3[1:0] matters for multiplies.
  logic [W2-1:0] mul_a, mul_b, mul_p;
  always_comb begin
    mul_a = (FUNC3[1:0] == 2'b11) ? {{XLEN{1'b0}}, OP1} : {{XLEN{OP1[XLEN-1]}}, OP1};
    mul_b = FUNC3[1] ? {{XLEN{1'b0}}, OP2} : {{XLEN{OP2[XLEN-1]}}, OP2};
    mul_p = mul_a * mul_b;
  end

  always_ff @(posedge CLK) begin
    if (state == S_IDLE) prod_q[0] <= mul_p;
    for (int i = 1; i < MUL_STAGES; i++) prod_q[i] <= prod_q[i-1];
  end

  logic [XLEN-1:0] mul_res;
  assign mul_res = (func_q[1:0] == 2'b00) ? prod_q[MUL_STAGES-1][XLEN-1:0]
                                          : prod_q[MUL_STAGES-1][W2-1:XLEN];

  // Divider operand conditioning and special-case detection
  logic            sgn, div_zero, div_ovf, reuse_hit, q_neg, r_neg;
  logic [XLEN-1:0] abs_a, abs_b, chk_quo, chk_rem, fix_quo, fix_rem;
  always_comb begin
    sgn       = ~func_q[0];
    abs_a     = (sgn && a_q[XLEN-1]) ? (~a_q + 1'b1) : a_q;
    abs_b     = (sgn && b_q[XLEN-1]) ? (~b_q + 1'b1) : b_q;
    div_zero  = (b_q == '0);
    div_ovf   = sgn && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    reuse_hit = reuse_v && (reuse_a == a_q) && (reuse_b == b_q) && (reuse_sgn == sgn);
    chk_quo   = div_zero ? '1 : a_q;
    chk_rem   = div_zero ? a_q : '0;
    q_neg     = sgn && (a_q[XLEN-1] ^ b_q[XLEN-1]);
    r_neg     = sgn && a_q[XLEN-1];
    fix_quo   = q_neg ? (~quo_q + 1'b1) : quo_q;
    fix_rem   = r_neg ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
  end

  // DIV_BITS restoring steps per cycle; the partial remainder stays below the divisor.
  logic [XLEN:0]   r_n;
  logic [XLEN-1:0] q_n;
  always_comb begin
    r_n = rem_q;
    q_n = quo_q;
    for (int i = 0; i < DIV_BITS; i++) begin
      r_n = {r_n[XLEN-1:0], q_n[XLEN-1]};
      q_n = {q_n[XLEN-2:0], 1'b0};
      if (r_n >= {1'b0, dvs_q}) begin
        r_n    = r_n - {1'b0, dvs_q};
        q_n[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= S_IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= '0;
      cnt     <= '0;
      reuse_v <= 1'b0;
    end else if (FLUSH) begin
      state   <= S_IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      reuse_v <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            func_q <= FUNC3;
            a_q    <= OP1;
            b_q    <= OP2;
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= FUNC3[2] ? S_DIV_CHK : S_MUL;
          end
        end
        S_MUL: begin
          if (cnt == CW'(MUL_STAGES - 1)) begin
            RESULT <= mul_res;
            DONE   <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV_CHK: begin
          if (reuse_hit) begin
            RESULT <= func_q[1] ? reuse_rem : reuse_quo;
            DONE   <= 1'b1;
            state  <= S_DONE;
          end else if (div_zero || div_ovf) begin
            RESULT    <= func_q[1] ? chk_rem : chk_quo;
            reuse_a   <= a_q;
            reuse_b   <= b_q;
            reuse_sgn <= sgn;
            reuse_quo <= chk_quo;
            reuse_rem <= chk_rem;
            reuse_v   <= 1'b1;
            DONE      <= 1'b1;
            state     <= S_DONE;
          end else begin
            rem_q <= '0;
            quo_q <= abs_a;
            dvs_q <= abs_b;
            cnt   <= '0;
            state <= S_DIV_ITER;
          end
        end
        S_DIV_ITER: begin
          rem_q <= r_n;
          quo_q <= q_n;
          if (cnt == CW'(ITERS - 1)) state <= S_DIV_FIX;
          else                        cnt   <= cnt + CW'(1);
        end
        S_DIV_FIX: begin
          RESULT    <= func_q[1] ? fix_rem : fix_quo;
          reuse_a   <= a_q;
          reuse_b   <= b_q;
          reuse_sgn <= sgn;
          reuse_quo <= fix_quo;
          reuse_rem <= fix_rem;
          reuse_v   <= 1'b1;
          DONE      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, multi-cycle corner sequences and
// randomized ops checked against an arithmetic reference model with reuse tracking.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int MS   = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, start, start2, flush;
  logic [2:0]      func3;
  logic [XLEN-1:0] op1, op2;
  logic            busy, done, busy2, done2;
  logic [XLEN-1:0] result, result2;
  logic [2:0]      dbg_state, dbg_state2;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS), .DIV_BITS(1)) dut (
    .CLK(clk), .RESET(reset_n), .START(start), .FUNC3(func3), .OP1(op1), .OP2(op2),
    .FLUSH(flush), .BUSY(busy), .DONE(done), .RESULT(result), .DBG_STATE(dbg_state)
  );

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MS), .DIV_BITS(2)) dut2 (
    .CLK(clk), .RESET(reset_n), .START(start2), .FUNC3(func3), .OP1(op1), .OP2(op2),
    .FLUSH(flush), .BUSY(busy2), .DONE(done2), .RESULT(result2), .DBG_STATE(dbg_state2)
  );

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference model: plain arithmetic plus the last completed div-class op
  bit              m_valid;
  logic [XLEN-1:0] m_a, m_b;
  bit              m_sgn;

  function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    longint          sa, sb, sub;
    longint unsigned ua, ub, pu;
    logic [XLEN-1:0] q, r;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sub = {32'b0, b};
    q   = '0;
    r   = '0;
    case (f)
      3'd0: return 32'(sa * sb);
      3'd1: return 32'((sa * sb) >>> 32);
      3'd2: return 32'((sa * sub) >>> 32);
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4, 3'd6: begin
        if (b == 0) begin q = '1; r = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q = a; r = '0; end
        else begin q = 32'(sa / sb); r = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin q = '1; r = a; end
        else begin q = 32'(ua / ub); r = 32'(ua % ub); end
      end
    endcase
    return f[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    bit s;
    s = ~f[0];
    if (!f[2]) return MS;
    if (b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    if (m_valid && m_a == a && m_b == b && m_sgn == s) return 1;
    return 2 + XLEN;
  endfunction

  task automatic model_note(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    if (f[2]) begin
      m_valid = 1'b1;
      m_a     = a;
      m_b     = b;
      m_sgn   = ~f[0];
    end
  endtask

  // driver: one op on dut (sel=0) or dut2 (sel=1), latency counted in edges after accept
  task automatic run_op(input bit sel, input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                        input int exp_latency, input string name);
    int n, busy_low;
    bit seen;
    logic [XLEN-1:0] act;
    @(negedge clk);
    func3 = f; op1 = a; op2 = b;
    if (sel) start2 = 1'b1; else start = 1'b1;
    exp_q.push_back(exp_res);
    @(posedge clk);
    #1 start = 1'b0; start2 = 1'b0;
    n = 0; seen = 1'b0; busy_low = 0; act = '0;
    while (!seen && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (sel ? done2 : done) begin
        seen = 1'b1;
        act  = sel ? result2 : result;
      end else if (!(sel ? busy2 : busy)) busy_low++;
    end
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_latency"}, 64'(n), 64'(exp_latency));
    check({name, "_busy_held"}, 64'(busy_low), 64'd0);
    if (exp_q.size() > 0) check({name, "_result"}, 64'(act), 64'(exp_q.pop_front()));
    @(posedge clk);
    @(negedge clk);
    check({name, "_idle_busy"}, 64'(sel ? busy2 : busy), 64'd0);
    check({name, "_idle_done"}, 64'(sel ? done2 : done), 64'd0);
  endtask

  typedef struct {
    logic [2:0]      f;
    logic [XLEN-1:0] a, b, res;
    int              lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, cyc, first_lat;
    logic [XLEN-1:0] first_res, ra, rb, held_exp;
    logic [2:0] rf;
    int mode;

    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; flush = 1'b0;
    func3 = '0; op1 = '0; op2 = '0;
    m_valid = 1'b0; m_a = '0; m_b = '0; m_sgn = 1'b0;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
    vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
    vecs[10] = '{3'd5, 32'd100,       32'd7,         32'd14,        34};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_result_db2", 64'(result2), 64'd0);
    reset_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 11; i++) begin
      run_op(1'b0, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));
      model_note(vecs[i].f, vecs[i].a, vecs[i].b);
    end

    // flush mid-divide clears reuse
    run_op(1'b0, 3'd4, 32'd1000, 32'd3, ref_result(3'd4, 32'd1000, 32'd3),
           exp_lat(3'd4, 32'd1000, 32'd3), "flush_prep");
    model_note(3'd4, 32'd1000, 32'd3);
    @(negedge clk);
    func3 = 3'd4; op1 = 32'd555; op2 = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("flush_no_done", 64'(pulses), 64'd0);
    run_op(1'b0, 3'd6, 32'd1000, 32'd3, ref_result(3'd6, 32'd1000, 32'd3),
           exp_lat(3'd6, 32'd1000, 32'd3), "rem_after_flush");
    model_note(3'd6, 32'd1000, 32'd3);

    // reset mid-multiply
    run_op(1'b0, 3'd0, 32'd3, 32'd5, 32'd15, MS, "mul_before_reset");
    @(negedge clk);
    func3 = 3'd0; op1 = 32'd6; op2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    m_valid = 1'b0;
    @(negedge clk);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_result", 64'(result), 64'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midreset_no_done", 64'(pulses), 64'd0);

    // START held high across a whole divide
    held_exp = ref_result(3'd5, 32'd12345, 32'd67);
    first_lat = -1; first_res = '0; pulses = 0; cyc = 0;
    @(negedge clk);
    func3 = 3'd5; op1 = 32'd12345; op2 = 32'd67; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first_lat < 0) begin first_lat = cyc; first_res = result; end
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_start_pulses", 64'(pulses), 64'd1);
    check("held_start_latency", 64'(first_lat), 64'd34);
    check("held_start_result", 64'(first_res), 64'(held_exp));
    model_note(3'd5, 32'd12345, 32'd67);

    // radix-4 divider instance
    run_op(1'b1, 3'd5, 32'd100, 32'd7, 32'd14, 18, "db2_divu");
    run_op(1'b1, 3'd7, 32'd100, 32'd7, 32'd2, 1, "db2_remu_reuse");

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rf   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      ra   = $urandom;
      rb   = $urandom;
      case (mode)
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: if (m_valid) begin ra = m_a; rb = m_b; rf = m_sgn ? {2'b11, 1'($urandom_range(0, 1)), 1'b0} : 3'd7; end
        3: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        default: ;
      endcase
      if (mode == 2 && m_valid) rf = m_sgn ? (($urandom_range(0, 1) == 1) ? 3'd4 : 3'd6)
                                           : (($urandom_range(0, 1) == 1) ? 3'd5 : 3'd7);
      run_op(1'b0, rf, ra, rb, ref_result(rf, ra, rb), exp_lat(rf, ra, rb), $sformatf("rnd%0d", i));
      model_note(rf, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle RV32M/RV64M multiply/divide execution unit for the 5-stage pipeline.
- Sits beside alu_int in the EX stage. The pipeline raises START for an M-extension op and stalls IF/ID/EX while BUSY is high, until DONE.
- Pipelined multiplier with configurable latency; radix-2^DIV_BITS iterative divider.
- Last-quotient/remainder reuse, so a DIV followed by a REM on the same operands completes in one cycle.

Parameters:
- XLEN, 32, datapath width; 32 or 64.
- MUL_STAGES, 2, multiply latency in cycles; 1..4.
- DIV_BITS, 1, quotient bits resolved per iteration; 1 or 2; XLEN % DIV_BITS == 0.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- START  in  1  request; sampled only when BUSY=0.
- FUNC3  in  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OP1  in  XLEN  rs1 value (dividend / multiplicand).
- OP2  in  XLEN  rs2 value (divisor / multiplier).
- FLUSH  in  1  abort the in-flight op (branch flush from flush unit).
- BUSY  out  1  high from the edge after accept through the DONE cycle inclusive.
- DONE  out  1  one-cycle pulse; RESULT valid only in this cycle.
- RESULT  out  XLEN  result; holds its last value outside DONE.

Behaviour:
- Priority at each edge: RESET=0 > FLUSH > START.
- Reset values: state IDLE, BUSY=0, DONE=0, RESULT=0, iteration counter=0, reuse-valid=0.
- States and transitions:
  - IDLE -> MUL or DIV_CHK on accept (START=1, BUSY=0); FUNC3 and operands are latched.
  - MUL -> DONE after MUL_STAGES-1 further edges.
  - DIV_CHK -> DONE on a special case or reuse hit; otherwise -> DIV_ITER.
  - DIV_ITER runs XLEN/DIV_BITS edges, then -> DIV_FIX.
  - DIV_FIX -> DONE.
  - DONE -> IDLE.
- Latency, for accept at edge k (DONE high in the cycle after the stated edge):
  - MUL*: edge k+MUL_STAGES.
  - DIV/REM special case or reuse hit: edge k+1.
  - DIV/REM normal: edge k+2+XLEN/DIV_BITS (k+34 for XLEN=32, DIV_BITS=1).
- START while BUSY=1 is ignored. Back-to-back: a new accept is possible on the edge ending the DONE cycle at the earliest (BUSY is still 1 then, so it is ignored), i.e. on the following edge.
- Multiply:
  - Operands are extended to 2*XLEN per op: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns product[XLEN-1:0]; MULH* return product[2XLEN-1:XLEN].
  - The product is registered through MUL_STAGES stages.
- Divide:
  - Signed ops divide absolute values; in DIV_FIX the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
  - Restoring algorithm; per iteration DIV_BITS quotient bits are shifted in.
- Special cases, resolved in DIV_CHK:
  - Divisor=0: quotient all-ones, remainder=OP1.
  - Signed overflow (OP1=min, OP2=-1): quotient=OP1, remainder=0.
- Reuse:
  - After a normally or specially completed DIV/DIVU/REM/REMU, the unit stores OP1, OP2, signedness, quotient and remainder, and sets reuse-valid=1.
  - A later div-class op with identical OP1, OP2 and signedness hits and returns the stored quotient or remainder.
  - Any MUL-class op leaves the reuse entry intact.
  - FLUSH or reset clears reuse-valid.
- FLUSH: from any state -> IDLE on that edge; BUSY=0 and DONE=0 next cycle; RESULT unchanged. FLUSH coincident with DONE suppresses nothing already emitted; the state goes to IDLE.
- Reset mid-operation: abandons the op with no DONE and applies the reset values above.
- Width: all internal arithmetic is exact to 2*XLEN; no truncation before final selection.

Test Plan:
- Multiply (XLEN=32, MUL_STAGES=2):
  - MUL OP1=7, OP2=0xFFFFFFFD -> DONE after edge k+2, RESULT=0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- Divide with reuse:
  - DIV 0xFFFFFFF9 / 2 -> DONE after edge k+34, RESULT=0xFFFFFFFD.
  - Immediately followed by REM on the same operands -> DONE after edge k'+1, RESULT=0xFFFFFFFF.
- Special cases:
  - DIVU 5/0 -> k+1, 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
- Flush:
  - FLUSH=1 at edge k+10 of a DIV -> no DONE pulse, BUSY=0 from k+11.
  - Following REM on the same operands takes the full 34-cycle latency (reuse cleared).
- Reset and ignored START:
  - RESET=0 for one edge mid-MUL -> BUSY=0, DONE=0, RESULT=0 next cycle.
  - START held with BUSY=1 during a DIV -> exactly one DONE pulse.
- DIV_BITS=2 regression: DIVU 100/7 -> DONE after edge k+18, RESULT=14; REMU on the same operands -> 2 via reuse at k+1.
